// File: rtl/mul_pkg.sv
// Shared constants for the pipelined Wallace-tree multiplier.
// Default operand widths and pipeline latency are defined here.
package mul_pkg;

    localparam int MUL_WA_DEFAULT = 24;
    localparam int MUL_WB_DEFAULT = 28;
    localparam int MUL_LATENCY    = 2;

endpackage

// File: rtl/wallace_csa_tree.sv
// Combinational sign-aware partial-product generation and Wallace 3:2 reduction
// down to a carry-save (sum, carry) pair of width WA+WB.
module wallace_csa_tree
    import mul_pkg::*;
#(
    parameter int WA = MUL_WA_DEFAULT,
    parameter int WB = MUL_WB_DEFAULT
) (
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    input  logic             sgn,
    output logic [WA+WB-1:0] sum,
    output logic [WA+WB-1:0] carry
);

    localparam int W  = WA + WB;
    localparam int NR = WB + 1;
    localparam int NP = NR + 2;

    logic [W-1:0] a_ext_s;
    logic         neg_msb_s;
    logic [W-1:0] pp_s [NP];

    function automatic logic [W-1:0] csa_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [W-1:0] csa_carry(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [W-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // Partial products; a signed multiplier MSB has negative weight, so that row is
    // added as its one's complement plus a +1 correction row.
    always_comb begin
        a_ext_s   = {{WB{sgn & a[WA-1]}}, a};
        neg_msb_s = sgn & b[WB-1];
        for (int j = 0; j < NP; j++) begin
            pp_s[j] = '0;
        end
        for (int j = 0; j < WB - 1; j++) begin
            pp_s[j] = b[j] ? (a_ext_s << j) : '0;
        end
        if (neg_msb_s) begin
            pp_s[WB-1] = ~(a_ext_s << (WB - 1));
            pp_s[WB]   = {{(W-1){1'b0}}, 1'b1};
        end else begin
            pp_s[WB-1] = b[WB-1] ? (a_ext_s << (WB - 1)) : '0;
            pp_s[WB]   = '0;
        end
    end

    // Wallace levels: each level compresses every full group of three rows into two and
    // passes the leftover rows through until only two remain.
    always_comb begin : reduce
        logic [W-1:0] cur [NP];
        logic [W-1:0] nxt [NP];
        int           cnt;
        int           grp;
        int           rem;
        cur = pp_s;
        cnt = NR;
        grp = 0;
        rem = 0;
        for (int lvl = 0; lvl < NR; lvl++) begin
            nxt = '{default: '0};
            grp = cnt / 3;
            rem = cnt % 3;
            for (int g = 0; g < NR / 3; g++) begin
                nxt[2*g]   = (g < grp) ? csa_sum(cur[3*g], cur[3*g+1], cur[3*g+2]) : '0;
                nxt[2*g+1] = (g < grp) ? csa_carry(cur[3*g], cur[3*g+1], cur[3*g+2]) : '0;
            end
            for (int k = 0; k < 2; k++) begin
                nxt[2*grp+k] = (k < rem) ? cur[3*grp+k] : nxt[2*grp+k];
            end
            cur = nxt;
            cnt = 2 * grp + rem;
        end
        sum   = cur[0];
        carry = cur[1];
    end

endmodule

// File: rtl/wallace_mul_pipe.sv
// Two-stage pipelined multiplier: S1 holds the carry-save pair, S2 the final product.
// Valid/ready flow control with bubble collapse; tag travels with each operation.
module wallace_mul_pipe
    import mul_pkg::*;
#(
    parameter int WA = MUL_WA_DEFAULT,
    parameter int WB = MUL_WB_DEFAULT,
    parameter int TW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    input  logic             sgn,
    input  logic [TW-1:0]    tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WA+WB-1:0] z,
    output logic [TW-1:0]    tag_out
);

    localparam int W = WA + WB;

    logic          en1_s;
    logic          en2_s;
    logic [W-1:0]  sum_s;
    logic [W-1:0]  carry_s;
    logic          v1_r;
    logic [W-1:0]  s1_sum_r;
    logic [W-1:0]  s1_carry_r;
    logic [TW-1:0] s1_tag_r;
    logic          v2_r;
    logic [W-1:0]  z_r;
    logic [TW-1:0] tag_r;

    wallace_csa_tree #(
        .WA (WA),
        .WB (WB)
    ) u_csa_tree (
        .a     (a),
        .b     (b),
        .sgn   (sgn),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // Stage enables: a stage advances when empty or when the stage after it advances.
    always_comb begin
        en2_s = ~v2_r | out_ready;
        en1_s = ~v1_r | en2_s;
    end

    assign in_ready  = en1_s;
    assign out_valid = v2_r;
    assign z         = z_r;
    assign tag_out   = tag_r;

    // S1: capture carry-save pair; data registers only load with a real operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r       <= 1'b0;
            s1_sum_r   <= '0;
            s1_carry_r <= '0;
            s1_tag_r   <= '0;
        end else if (en1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_sum_r   <= sum_s;
                s1_carry_r <= carry_s;
                s1_tag_r   <= tag_in;
            end
        end
    end

    // S2: final carry-propagate add; the carry-out beyond W bits is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r  <= 1'b0;
            z_r   <= '0;
            tag_r <= '0;
        end else if (en2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                z_r   <= s1_sum_r + s1_carry_r;
                tag_r <= s1_tag_r;
            end
        end
    end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Self-checking bench: directed vector table, flow-control sequences, and a random
// stream run on three width configurations against an arithmetic reference model.
module tb_wallace_mul_pipe;
    import mul_pkg::*;

    typedef struct {
        logic        s;
        logic [23:0] a;
        logic [27:0] b;
        logic [3:0]  tag;
        logic [51:0] z;
    } vec_t;

    typedef struct {
        logic [63:0] z;
        logic [3:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        sgn;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    logic [3:0]  tag_in;

    logic        rdy8,  ov8,  rdy24, ov24, rdy32, ov32;
    logic [15:0] z8;
    logic [51:0] z24;
    logic [63:0] z32;
    logic [3:0]  tg8, tg24, tg32;

    int   checks  = 0;
    int   errors  = 0;
    int   acc_cnt = 0;
    exp_t exp_q [3][$];
    int   wa_tab [3] = '{8, 24, 32};
    int   wb_tab [3] = '{8, 28, 32};
    vec_t vecs [10];

    always #5 clk = ~clk;

    wallace_mul_pipe #(.WA(8), .WB(8), .TW(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .sgn(sgn), .tag_in(tag_in),
        .out_valid(ov8), .out_ready(out_ready), .z(z8), .tag_out(tg8)
    );

    wallace_mul_pipe #(.WA(24), .WB(28), .TW(4)) u_dut24 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy24),
        .a(a_drv[23:0]), .b(b_drv[27:0]), .sgn(sgn), .tag_in(tag_in),
        .out_valid(ov24), .out_ready(out_ready), .z(z24), .tag_out(tg24)
    );

    wallace_mul_pipe #(.WA(32), .WB(32), .TW(4)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .a(a_drv), .b(b_drv), .sgn(sgn), .tag_in(tag_in),
        .out_valid(ov32), .out_ready(out_ready), .z(z32), .tag_out(tg32)
    );

    // Reference: extend each operand to 64 bits by its signedness, multiply, keep WA+WB bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int wa, input int wb, input logic s);
        logic [63:0] ae, be, m;
        ae = 64'(a) & ((64'd1 << wa) - 64'd1);
        be = 64'(b) & ((64'd1 << wb) - 64'd1);
        if (s && ae[wa-1]) ae = ae | (~64'd0 << wa);
        if (s && be[wb-1]) be = be | (~64'd0 << wb);
        m = (wa + wb >= 64) ? ~64'd0 : ((64'd1 << (wa + wb)) - 64'd1);
        return (ae * be) & m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic sb_sample();
        logic [63:0] zv [3];
        logic [3:0]  tv [3];
        logic        ov [3];
        logic        rd [3];
        exp_t        e;
        zv = '{64'(z8), 64'(z24), z32};
        tv = '{tg8, tg24, tg32};
        ov = '{ov8, ov24, ov32};
        rd = '{rdy8, rdy24, rdy32};
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                exp_q[d].delete();
            end else begin
                if (ov[d] === 1'b1 && out_ready) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb%0d_unexpected got=%h want=none", d, zv[d]);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk($sformatf("sb%0d_z", d), zv[d], e.z);
                        chk($sformatf("sb%0d_tag", d), 64'(tv[d]), 64'(e.tag));
                    end
                end
                if (in_valid && rd[d] === 1'b1) begin
                    e.z   = ref_mul(a_drv, b_drv, wa_tab[d], wb_tab[d], sgn);
                    e.tag = tag_in;
                    exp_q[d].push_back(e);
                    if (d == 1) acc_cnt++;
                end
            end
        end
    endtask

    // Every cycle: neg() samples mid-cycle, cyc_end() moves just past the next rising edge.
    task automatic neg();
        @(negedge clk);
        sb_sample();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        sgn = v.s; a_drv = 32'(v.a); b_drv = 32'(v.b); tag_in = v.tag;
        in_valid = 1'b1; out_ready = 1'b1;
        neg();
        chk($sformatf("vec%0d_accept", idx), 64'(rdy24), 64'd1);
        cyc_end();
        in_valid = 1'b0;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            neg();
            chk($sformatf("vec%0d_early", idx), 64'(ov24), 64'd0);
            cyc_end();
        end
        neg();
        chk($sformatf("vec%0d_valid", idx), 64'(ov24), 64'd1);
        chk($sformatf("vec%0d_z", idx), 64'(z24), 64'(v.z));
        chk($sformatf("vec%0d_tag", idx), 64'(tg24), 64'(v.tag));
        cyc_end();
    endtask

    initial begin
        int stale;
        int acc;
        int idx;
        int base;
        int cyc;
        logic [31:0] opa [3];
        logic [31:0] opb [3];

        vecs[0] = '{1'b0, 24'hFFFFFF, 28'hFFFFFFF, 4'h5, 52'hFFFFFEF000001};
        vecs[1] = '{1'b1, 24'hFFFFFF, 28'h0000003, 4'h6, 52'hFFFFFFFFFFFFD};
        vecs[2] = '{1'b1, 24'h800000, 28'h8000000, 4'h7, 52'h4000000000000};
        vecs[3] = '{1'b0, 24'h800000, 28'h8000000, 4'h8, 52'h4000000000000};
        vecs[4] = '{1'b1, 24'hFFFFFE, 28'hFFFFFFF, 4'h9, 52'h0000000000002};
        vecs[5] = '{1'b1, 24'h000005, 28'hFFFFFFE, 4'hA, 52'hFFFFFFFFFFFF6};
        vecs[6] = '{1'b0, 24'h123456, 28'h0000010, 4'hB, 52'h0000001234560};
        vecs[7] = '{1'b0, 24'h000000, 28'hFFFFFFF, 4'hC, 52'h0000000000000};
        vecs[8] = '{1'b1, 24'h7FFFFF, 28'h7FFFFFF, 4'hD, 52'h3FFFFF7800001};
        vecs[9] = '{1'b0, 24'hFFFFFF, 28'h0000003, 4'hE, 52'h00000002FFFFFD};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sgn = 1'b0;
        a_drv = 32'd0; b_drv = 32'd0; tag_in = 4'd0;
        repeat (3) begin neg(); cyc_end(); end
        rst = 1'b0;
        neg();
        chk("reset_out_valid", 64'(ov24), 64'd0);
        chk("reset_z", 64'(z24), 64'd0);
        chk("reset_tag", 64'(tg24), 64'd0);
        chk("reset_in_ready", 64'(rdy24), 64'd1);
        cyc_end();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Back-to-back stream 2*3, 4*5, 6*7 with products on consecutive cycles.
        sgn = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        a_drv = 32'd2; b_drv = 32'd3; tag_in = 4'h1;
        neg(); cyc_end();
        a_drv = 32'd4; b_drv = 32'd5; tag_in = 4'h2;
        neg(); chk("stream_gap", 64'(ov24), 64'd0); cyc_end();
        a_drv = 32'd6; b_drv = 32'd7; tag_in = 4'h3;
        neg(); chk("stream_z0", 64'(z24), 64'd6); chk("stream_v0", 64'(ov24), 64'd1); cyc_end();
        in_valid = 1'b0;
        neg(); chk("stream_z1", 64'(z24), 64'd20); chk("stream_v1", 64'(ov24), 64'd1); cyc_end();
        neg(); chk("stream_z2", 64'(z24), 64'd42); chk("stream_v2", 64'(ov24), 64'd1); cyc_end();
        neg(); chk("stream_empty", 64'(ov24), 64'd0); cyc_end();

        // Backpressure: three ops offered while the consumer stalls for four cycles.
        opa = '{32'd3, 32'd4, 32'd5};
        opb = '{32'd3, 32'd4, 32'd5};
        out_ready = 1'b0; idx = 0; acc = 0;
        for (int c = 0; c < 4; c++) begin
            a_drv = opa[idx]; b_drv = opb[idx]; tag_in = 4'(idx); in_valid = 1'b1;
            neg();
            if (rdy24) begin acc++; idx++; end
            cyc_end();
        end
        chk("bp_accepted", 64'(acc), 64'd2);
        neg();
        chk("bp_in_ready", 64'(rdy24), 64'd0);
        chk("bp_hold_v", 64'(ov24), 64'd1);
        chk("bp_hold_z", 64'(z24), 64'd9);
        cyc_end();
        out_ready = 1'b1;
        neg();
        chk("bp_drain_z0", 64'(z24), 64'd9);
        chk("bp_third_accept", 64'(rdy24), 64'd1);
        cyc_end();
        in_valid = 1'b0;
        neg(); chk("bp_drain_z1", 64'(z24), 64'd16); cyc_end();
        neg(); chk("bp_drain_z2", 64'(z24), 64'd25); chk("bp_drain_tag2", 64'(tg24), 64'd2); cyc_end();
        neg(); chk("bp_empty", 64'(ov24), 64'd0); cyc_end();

        // Reset with two operations in flight and a third offered during reset.
        in_valid = 1'b1; a_drv = 32'd10; b_drv = 32'd11; tag_in = 4'h4;
        neg(); cyc_end();
        a_drv = 32'd12; b_drv = 32'd13; tag_in = 4'h5;
        neg(); cyc_end();
        rst = 1'b1; a_drv = 32'd14; b_drv = 32'd15; tag_in = 4'h6;
        neg(); cyc_end();
        rst = 1'b0; in_valid = 1'b0;
        neg();
        chk("rst_out_valid", 64'(ov24), 64'd0);
        chk("rst_z", 64'(z24), 64'd0);
        chk("rst_tag", 64'(tg24), 64'd0);
        chk("rst_in_ready", 64'(rdy24), 64'd1);
        cyc_end();
        stale = 0;
        repeat (4) begin
            neg();
            if (ov24 !== 1'b0) stale++;
            cyc_end();
        end
        chk("rst_no_stale", 64'(stale), 64'd0);

        // Random stream on all three configurations.
        base = acc_cnt; cyc = 0;
        while ((acc_cnt - base) < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sgn       = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a_drv = 32'hFFFFFFFF;
                1:       a_drv = 32'h80000080;
                2:       a_drv = 32'd0;
                default: a_drv = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b_drv = 32'hFFFFFFFF;
                1:       b_drv = 32'h08000080;
                default: b_drv = $urandom;
            endcase
            tag_in = 4'($urandom);
            neg(); cyc_end();
            cyc++;
        end
        chk("rand_op_count", 64'((acc_cnt - base) >= 10000), 64'd1);

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) begin neg(); cyc_end(); end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("drain_empty%0d", d), 64'(exp_q[d].size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
